ysyx_23060208_regfile_mp: RTL and testbench

//  Multi-port integer register file; parametrised successor to the 1W/2R regfile.
//  - Serves NR_READ read ports and NR_WRITE write ports from one array.
//  - Clears the array with a sequential sweep after reset or on request.
//  - Sits between decode (read ports) and writeback/commit (write ports) in the NPC core.

---
 rtl/ysyx_23060208_regfile_mp.sv | 109 ++++++++++
 tb/tb_ysyx_23060208_regfile_mp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_regfile_mp.sv
// Multi-port integer register file with NR_READ read ports, NR_WRITE write ports and a
// sequential clear sweep. Optional write-to-read forwarding: YSYX_23060208_RF_BYPASS_EN.
module ysyx_23060208_regfile_mp #(
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clr,
  input  logic [NR_WRITE-1:0]            wen,
  input  logic [NR_WRITE*REG_WIDTH-1:0]  waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NR_READ*REG_WIDTH-1:0]   raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
  output logic                           busy
);

  localparam int DEPTH = 1 << REG_WIDTH;
  localparam logic [REG_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [REG_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {
    SWEEP,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [REG_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   clear_en;
  logic [DATA_WIDTH-1:0]  rf [DEPTH];

  assign busy = reset | (state_q == SWEEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= CNT_ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A clr during the sweep restarts it without clearing the current entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_en = 1'b0;
    case (state_q)
      SWEEP: begin
        if (clr) begin
          cnt_d = CNT_ONE;
        end else begin
          clear_en = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (clr) begin
          state_d = SWEEP;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = CNT_ONE;
      end
    endcase
  end

  // Later ports are applied last, so the highest enabled index wins an address conflict.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == SWEEP) begin
        if (clear_en) begin
          rf[cnt_q] <= '0;
        end
      end else begin
        for (int i = 0; i < NR_WRITE; i++) begin
          if (wen[i] && (waddr[i*REG_WIDTH +: REG_WIDTH] != '0)) begin
            rf[waddr[i*REG_WIDTH +: REG_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < NR_READ; j++) begin
      if (!busy && (raddr[j*REG_WIDTH +: REG_WIDTH] != '0)) begin
        rdata[j*DATA_WIDTH +: DATA_WIDTH] = rf[raddr[j*REG_WIDTH +: REG_WIDTH]];
`ifdef YSYX_23060208_RF_BYPASS_EN
        for (int i = 0; i < NR_WRITE; i++) begin
          if (wen[i] && (waddr[i*REG_WIDTH +: REG_WIDTH] == raddr[j*REG_WIDTH +: REG_WIDTH])) begin
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_regfile_mp.sv
// Scoreboard bench for ysyx_23060208_regfile_mp: directed scenarios plus random traffic,
// checked against an abstract register-file model.
module tb_ysyx_23060208_regfile_mp;

  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 1 << RW;

  logic              clock = 1'b0;
  logic              reset;
  logic              clr;
  logic [NW-1:0]     wen;
  logic [NW*RW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NR*RW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic              busy;

  typedef struct packed {
    logic            busy;
    logic [NR*DW-1:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Abstract model: contents plus number of busy cycles still to go; a finished sweep zeroes all.
  logic [DW-1:0] m_rf [DEPTH];
  int            m_remaining = DEPTH - 1;

  ysyx_23060208_regfile_mp #(
    .REG_WIDTH(RW), .DATA_WIDTH(DW), .NR_READ(NR), .NR_WRITE(NW)
  ) dut (
    .clock(clock), .reset(reset), .clr(clr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic exp_t expect_out();
    exp_t e;
    logic [RW-1:0] a;
    logic [DW-1:0] v;
    e.busy  = reset || (m_remaining > 0);
    e.rdata = '0;
    for (int j = 0; j < NR; j++) begin
      a = raddr[j*RW +: RW];
      v = m_rf[a];
`ifdef YSYX_23060208_RF_BYPASS_EN
      for (int i = 0; i < NW; i++)
        if (wen[i] && waddr[i*RW +: RW] == a) v = wdata[i*DW +: DW];
`endif
      if (e.busy || a == 0) v = '0;
      e.rdata[j*DW +: DW] = v;
    end
    return e;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_remaining = DEPTH - 1;
    end else if (m_remaining > 0) begin
      if (clr) m_remaining = DEPTH - 1;
      else begin
        m_remaining--;
        if (m_remaining == 0)
          for (int k = 0; k < DEPTH; k++) m_rf[k] = '0;
      end
    end else begin
      for (int i = 0; i < NW; i++)
        if (wen[i] && waddr[i*RW +: RW] != 0) m_rf[waddr[i*RW +: RW]] = wdata[i*DW +: DW];
      if (clr) m_remaining = DEPTH - 1;
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic c, input logic [NW-1:0] we,
                                input logic [NW*RW-1:0] wa, input logic [NW*DW-1:0] wd,
                                input logic [NR*RW-1:0] ra);
    reset = rst;
    clr   = c;
    wen   = we;
    waddr = wa;
    wdata = wd;
    raddr = ra;
    exp_q.push_back(expect_out());
    @(posedge clock);
    model_step();
    #1;
  endtask

  function automatic logic [RW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return RW'($urandom_range(0, 7));
    return RW'($urandom_range(0, DEPTH - 1));
  endfunction

  function automatic logic [NR*RW-1:0] rand_raddr();
    logic [NR*RW-1:0] r;
    for (int j = 0; j < NR; j++) r[j*RW +: RW] = rand_addr();
    return r;
  endfunction

  task automatic idle_read(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, '0, '0, '0, rand_raddr());
  endtask

  task automatic random_cycle(input bit allow_ctrl);
    logic [NW*RW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic [NR*RW-1:0] ra;
    for (int i = 0; i < NW; i++) begin
      wa[i*RW +: RW] = rand_addr();
      wd[i*DW +: DW] = $urandom();
    end
    ra = rand_raddr();
    if ($urandom_range(0, 2) == 0) ra[RW-1:0] = wa[RW +: RW];
    apply_stimulus(allow_ctrl && ($urandom_range(0, 299) == 0),
                   allow_ctrl && ($urandom_range(0, 79) == 0),
                   NW'($urandom_range(0, (1 << NW) - 1)), wa, wd, ra);
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL busy at %0t: got %0b expected %0b", $time, busy, e.busy);
    end
    for (int j = 0; j < NR; j++) begin
      checks++;
      if (rdata[j*DW +: DW] !== e.rdata[j*DW +: DW]) begin
        errors++;
        $display("[TB] FAIL rdata%0d at %0t (raddr=%0d): got %h expected %h", j, $time,
                 raddr[j*RW +: RW], rdata[j*DW +: DW], e.rdata[j*DW +: DW]);
      end
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) m_rf[k] = '0;
    reset = 1'b1; clr = 1'b0; wen = '0; waddr = '0; wdata = '0; raddr = '0;
    @(posedge clock);
    #1;

    // Reset for one cycle, then the full initial sweep.
    apply_stimulus(1'b1, 1'b0, '0, '0, '0, rand_raddr());
    idle_read(DEPTH + 3);

    apply_stimulus(1'b0, 1'b0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, {5'd0, 5'd5});
    apply_stimulus(1'b0, 1'b0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h12345678}, {5'd5, 5'd0});
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, {5'd5, 5'd0});

    apply_stimulus(1'b0, 1'b0, 2'b11, {5'd7, 5'd7}, {32'h2, 32'h1}, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, {5'd7, 5'd7});

    apply_stimulus(1'b0, 1'b0, 2'b10, {5'd9, 5'd0}, {32'h55, 32'h0}, {5'd0, 5'd9});
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, {5'd9, 5'd9});

    // Fill every entry, then clear with a sweep while writes keep arriving.
    for (int r = 1; r < DEPTH; r += 2)
      apply_stimulus(1'b0, 1'b0, 2'b11, {RW'(r + 1), RW'(r)},
                     {32'hA000_0000 + 32'(r + 1), 32'hA000_0000 + 32'(r)}, '0);
    for (int r = 0; r < DEPTH; r += 2) apply_stimulus(1'b0, 1'b0, '0, '0, '0, {RW'(r + 1), RW'(r)});
    apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0);
    for (int k = 0; k < DEPTH + 2; k++) random_cycle(1'b0);
    for (int r = 0; r < DEPTH; r += 2) apply_stimulus(1'b0, 1'b0, '0, '0, '0, {RW'(r + 1), RW'(r)});

    // Reset mid-sweep, then clr during the restarted sweep.
    apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0);
    idle_read(9);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0);
    idle_read(5);
    apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0);
    for (int k = 0; k < DEPTH + 4; k++) random_cycle(1'b0);

    for (int k = 0; k < 4000; k++) random_cycle(1'b1);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
